bus_register_bank: RTL

//  Parametrised bank of NUM_REGS general registers on the shared tri-state CPU BUS.
//  It replaces the per-register instances (A, B, THREE..SEVEN, OUT) with one block.

---
 rtl/bat_pkg.sv | 38 +++
 rtl/bank_cell.sv | 73 +++++++
 rtl/bus_register_bank.sv | 116 +++++++++++
 3 files changed

// File: rtl/bat_pkg.sv
// Shared constants and elaboration-time helpers for the bus register bank.
package bat_pkg;

  // Count direction encodings for CNT_DIR.
  localparam logic CNT_UP   = 1'b0;
  localparam logic CNT_DOWN = 1'b1;

  // Widest bank supported; sizes the read-enable population count.
  localparam int MAX_REGS = 32;
  localparam int POPW     = 6;

  // Ceiling log2, usable in parameter expressions.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'sd1 << i) < value) begin
        result = i + 1;
      end else begin
        result = result;
      end
    end
    return result;
  endfunction

  // Width of an ALU select port; never narrower than one bit.
  function automatic int sel_width(input int num_regs);
    int w;
    w = clog2(num_regs);
    if (w < 1) begin
      w = 1;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage

// File: rtl/bank_cell.sv
// One bank register: bus load, up/down count with wrap or saturate,
// gated bus drive data and a zero flag.
module bank_cell
  import bat_pkg::*;
#(
  parameter int               WIDTH     = 16,
  parameter int               SAT_MODE  = 0,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] bus_in,
  input  logic             ld_en,
  input  logic             cnt_en,
  input  logic             cnt_dir,
  input  logic             rd_grant,
  output logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] drive_data,
  output logic             zero
);

  localparam logic [WIDTH-1:0] ALL_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] value_r;
  logic [WIDTH-1:0] cnt_next_s;
  logic [WIDTH-1:0] next_s;

  // Counter step: +/-1, clamped at the ends when saturating.
  always_comb begin
    cnt_next_s = value_r;
    if (cnt_dir == CNT_UP) begin
      if ((SAT_MODE != 0) && (value_r == ALL_ONES)) begin
        cnt_next_s = value_r;
      end else begin
        cnt_next_s = value_r + ONE;
      end
    end else begin
      if ((SAT_MODE != 0) && (value_r == ALL_ZERO)) begin
        cnt_next_s = value_r;
      end else begin
        cnt_next_s = value_r - ONE;
      end
    end
  end

  // Update priority: load beats count, count beats hold.
  always_comb begin
    next_s = value_r;
    if (ld_en) begin
      next_s = bus_in;
    end else if (cnt_en) begin
      next_s = cnt_next_s;
    end else begin
      next_s = value_r;
    end
  end

  // Register state; async reset discards any pending load or count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_r <= RESET_VAL;
    end else begin
      value_r <= next_s;
    end
  end

  assign value      = value_r;
  assign drive_data = rd_grant ? value_r : ALL_ZERO;
  assign zero       = (value_r == ALL_ZERO);

endmodule

// File: rtl/bus_register_bank.sv
// Bank of general registers on the shared tri-state bus, with two ALU
// read ports, an OUT mirror, per-register zero flags and a sticky
// bus-contention flag.
module bus_register_bank
  import bat_pkg::*;
#(
  parameter int               WIDTH     = 16,
  parameter int               NUM_REGS  = 8,
  parameter int               OUT_IDX   = 7,
  parameter int               SAT_MODE  = 0,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
  localparam int              SELW      = sel_width(NUM_REGS)
) (
  input  logic                CLOCK,
  input  logic                RESET,
  inout  wire  [WIDTH-1:0]    BUS,
  input  logic [NUM_REGS-1:0] RD_EN,
  input  logic [NUM_REGS-1:0] LD_EN,
  input  logic [NUM_REGS-1:0] CNT_EN,
  input  logic                CNT_DIR,
  input  logic [SELW-1:0]     SEL_A,
  input  logic [SELW-1:0]     SEL_B,
  output logic [WIDTH-1:0]    ALU_A,
  output logic [WIDTH-1:0]    ALU_B,
  output logic [WIDTH-1:0]    OUT,
  output logic [NUM_REGS-1:0] ZERO,
  output logic                CONFLICT,
  input  logic                CLR_CONFLICT
);

  localparam logic [WIDTH-1:0] ALL_ZERO = {WIDTH{1'b0}};

  logic [WIDTH-1:0] reg_value_s [NUM_REGS];
  logic [WIDTH-1:0] cell_drive_s [NUM_REGS];
  logic [POPW-1:0]  rd_count_s;
  logic             one_reader_s;
  logic             multi_reader_s;
  logic [WIDTH-1:0] drive_data_s;
  logic [WIDTH-1:0] alu_a_s;
  logic [WIDTH-1:0] alu_b_s;
  logic             conflict_r;

  // Count how many registers want the bus this cycle.
  always_comb begin
    rd_count_s = {POPW{1'b0}};
    for (int i = 0; i < NUM_REGS; i++) begin
      rd_count_s = rd_count_s + POPW'(RD_EN[i]);
    end
  end

  assign one_reader_s   = (rd_count_s == 6'd1);
  assign multi_reader_s = (rd_count_s >= 6'd2);

  genvar g;
  generate
    for (g = 0; g < NUM_REGS; g++) begin : g_cell
      bank_cell #(
        .WIDTH    (WIDTH),
        .SAT_MODE (SAT_MODE),
        .RESET_VAL(RESET_VAL)
      ) u_cell (
        .clk       (CLOCK),
        .rst_n     (RESET),
        .bus_in    (BUS),
        .ld_en     (LD_EN[g]),
        .cnt_en    (CNT_EN[g]),
        .cnt_dir   (CNT_DIR),
        .rd_grant  (RD_EN[g] & one_reader_s),
        .value     (reg_value_s[g]),
        .drive_data(cell_drive_s[g]),
        .zero      (ZERO[g])
      );
    end
  endgenerate

  // Merge the gated cell drive values; at most one cell is non-zero.
  always_comb begin
    drive_data_s = ALL_ZERO;
    for (int i = 0; i < NUM_REGS; i++) begin
      drive_data_s = drive_data_s | cell_drive_s[i];
    end
  end

  // Release the bus unless exactly one bank register was selected.
  assign BUS = one_reader_s ? drive_data_s : {WIDTH{1'bz}};

  // ALU read muxes; an out-of-range select reads as zero.
  always_comb begin
    alu_a_s = ALL_ZERO;
    alu_b_s = ALL_ZERO;
    for (int i = 0; i < NUM_REGS; i++) begin
      alu_a_s = (SEL_A == SELW'(i)) ? reg_value_s[i] : alu_a_s;
      alu_b_s = (SEL_B == SELW'(i)) ? reg_value_s[i] : alu_b_s;
    end
  end

  assign ALU_A = alu_a_s;
  assign ALU_B = alu_b_s;
  assign OUT   = reg_value_s[OUT_IDX];

  // Sticky contention flag; a new conflict outranks a clear request.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      conflict_r <= 1'b0;
    end else if (multi_reader_s) begin
      conflict_r <= 1'b1;
    end else if (CLR_CONFLICT) begin
      conflict_r <= 1'b0;
    end else begin
      conflict_r <= conflict_r;
    end
  end

  assign CONFLICT = conflict_r;

endmodule
